// File: rtl/in_sampler.sv
// in_sampler: synchronises and whole-word debounces two raw switch banks, and keeps a
// sticky per-bank change mask that the processor clears with a one-cycle ack.
module in_sampler #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 4095
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] sw1,
  input  logic [WIDTH-1:0] sw2,
  input  logic             ack,
  output logic [WIDTH-1:0] inpval1,
  output logic [WIDTH-1:0] inpval2,
  output logic             changed,
  output logic [1:0]       change_mask
);
  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [15:0] CNT_LOAD = 16'(DEBOUNCE - 1);

  logic [WIDTH-1:0] raw        [2];
  logic [WIDTH-1:0] stable_val [2];
  logic [1:0]       commit_evt;
  logic [1:0]       mask_reg, mask_next;
  logic             changed_reg;

  assign raw[0] = sw1;
  assign raw[1] = sw2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [WIDTH-1:0] s1_reg, s2_reg;
      logic [WIDTH-1:0] cand_reg, cand_next;
      logic [WIDTH-1:0] stable_reg, stable_next;
      logic [15:0]      cnt_reg, cnt_next;
      state_t           state_reg, state_next;
      logic             evt;

      always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
          s1_reg     <= '0;
          s2_reg     <= '0;
          cand_reg   <= '0;
          stable_reg <= '0;
          cnt_reg    <= 16'd0;
          state_reg  <= IDLE;
        end else begin
          s1_reg     <= raw[gi];
          s2_reg     <= s1_reg;
          cand_reg   <= cand_next;
          stable_reg <= stable_next;
          cnt_reg    <= cnt_next;
          state_reg  <= state_next;
        end
      end

      // Any deviation from the candidate restarts the hold count.
      always_comb begin
        state_next  = state_reg;
        cand_next   = cand_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        evt         = 1'b0;
        case (state_reg)
          IDLE: begin
            if (s2_reg != stable_reg) begin
              cand_next  = s2_reg;
              cnt_next   = CNT_LOAD;
              state_next = SETTLE;
            end
          end
          SETTLE: begin
            if (s2_reg != cand_reg) begin
              cand_next = s2_reg;
              cnt_next  = CNT_LOAD;
            end else if (cnt_reg != 16'd0) begin
              cnt_next = cnt_reg - 16'd1;
            end else begin
              state_next = IDLE;
              // A glitch that settled back on the old value commits silently.
              if (cand_reg != stable_reg) begin
                stable_next = cand_reg;
                evt         = 1'b1;
              end
            end
          end
          default: state_next = IDLE;
        endcase
      end

      assign commit_evt[gi] = evt;
      assign stable_val[gi] = stable_reg;
    end
  endgenerate

  // A new event wins over a simultaneous ack.
  always_comb begin
    mask_next = commit_evt | (ack ? 2'b00 : mask_reg);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mask_reg    <= 2'b00;
      changed_reg <= 1'b0;
    end else begin
      mask_reg    <= mask_next;
      changed_reg <= |mask_next;
    end
  end

  assign inpval1     = stable_val[0];
  assign inpval2     = stable_val[1];
  assign change_mask = mask_reg;
  assign changed     = changed_reg;
endmodule
